// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults, raster FSM states and pixel type.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam int unsigned COLOR_W_DEF  = 8;

   function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   localparam int unsigned H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int unsigned V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

   typedef enum logic [1:0] {StWaitLock, StSeekSop, StRun} vga_state_e;

   typedef struct packed {
      logic [COLOR_W_DEF-1:0] r;
      logic [COLOR_W_DEF-1:0] g;
      logic [COLOR_W_DEF-1:0] b;
   } vga_pixel_t;

endpackage

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster counters with active, sync and origin decode.
module vga_raster_cnt
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic active,
   output logic hsync,
   output logic vsync,
   output logic origin
);

   localparam int unsigned H_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned H_W      = $clog2(H_TOTAL);
   localparam int unsigned V_W      = $clog2(V_TOTAL);
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic [H_W-1:0] h_cnt;
   logic [V_W-1:0] v_cnt;

   // Disabled counters park at the origin so the next run starts a fresh frame.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_W'(H_TOTAL - 1)) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_W'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_comb begin
      active = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
      hsync  = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
      vsync  = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
      origin = (h_cnt == '0) && (v_cnt == '0);
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator and pixel sink: lock gating, SOP alignment FSM, registered video outputs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
   parameter int unsigned H_FP      = H_FP_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BP      = H_BP_DEF,
   parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
   parameter int unsigned V_FP      = V_FP_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BP      = V_BP_DEF,
   parameter bit          SYNC_POL  = 1'b0,
   parameter int unsigned LOCK_WAIT = 1024,
   parameter int unsigned COLOR_W   = COLOR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pll_locked,
   input  logic [3*COLOR_W-1:0] pix_data,
   input  logic                 pix_valid,
   input  logic                 pix_sop,
   output logic                 pix_ready,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b,
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic                 vga_blank_n,
   output logic                 frame_start,
   output logic                 underflow
);

   localparam int unsigned LOCK_W = $clog2(LOCK_WAIT + 1);

   vga_state_e        state_q;
   logic [LOCK_W-1:0] lock_cnt_q;
   logic              cnt_en, active, hsync, vsync, origin;
   logic              sop_seen, take, err, accept;

   assign cnt_en = pll_locked && (state_q != StWaitLock);

   vga_raster_cnt #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_raster (
      .clk    (clk),
      .rst    (rst),
      .en     (cnt_en),
      .active (active),
      .hsync  (hsync),
      .vsync  (vsync),
      .origin (origin)
   );

   // A held SOP beat at the origin is displayed directly from SEEK_SOP, so frame (0,0) is not lost.
   always_comb begin
      sop_seen  = pix_valid && pix_sop;
      take      = active && ((state_q == StRun) || ((state_q == StSeekSop) && origin && sop_seen));
      err       = take && (!pix_valid || (origin ? !pix_sop : pix_sop));
      accept    = take && !err;
      pix_ready = 1'b0;
      if (!rst && pll_locked) begin
         case (state_q)
            StSeekSop: pix_ready = !sop_seen || origin;
            StRun:     pix_ready = active && !(sop_seen && !origin);
            default:   pix_ready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      if (rst) begin
         state_q    <= StWaitLock;
         lock_cnt_q <= '0;
         underflow  <= 1'b0;
      end else if (!pll_locked) begin
         state_q    <= StWaitLock;
         lock_cnt_q <= '0;
      end else if (state_q == StWaitLock) begin
         if (lock_cnt_q == LOCK_W'(LOCK_WAIT - 1)) begin
            state_q <= StSeekSop;
         end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
         end
      end else begin
         vga_hs      <= hsync ? SYNC_POL : ~SYNC_POL;
         vga_vs      <= vsync ? SYNC_POL : ~SYNC_POL;
         vga_blank_n <= take;
         frame_start <= origin;
         if (accept) begin
            {vga_r, vga_g, vga_b} <= pix_data;
         end
         if (err) begin
            underflow <= 1'b1;
            state_q   <= StSeekSop;
         end else if (take) begin
            state_q <= StRun;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster with a frame-reader source model.
module tb_vga_timing_gen;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam int NPIX = HA * VA;
   localparam int LW = 16;
   localparam bit POL = 1'b0;

   logic        clk = 1'b0;
   logic        rst, pll_locked, pix_valid, pix_sop, pix_ready;
   logic [23:0] pix_data;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n, frame_start, underflow;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
      .SYNC_POL (POL), .LOCK_WAIT (LW), .COLOR_W (8)
   ) dut (
      .clk (clk), .rst (rst), .pll_locked (pll_locked),
      .pix_data (pix_data), .pix_valid (pix_valid), .pix_sop (pix_sop), .pix_ready (pix_ready),
      .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
      .vga_hs (vga_hs), .vga_vs (vga_vs), .vga_blank_n (vga_blank_n),
      .frame_start (frame_start), .underflow (underflow)
   );

   typedef struct {
      logic [28:0] outs;
      logic        rdy;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [28:0] mon_got;
   int          tests = 0;
   int          fails = 0;

   // Reference model: mode 0 = waiting for lock, 1 = seeking SOP, 2 = displaying.
   int          m_mode, m_lock, m_pos;
   bit          m_uf;
   logic [28:0] m_outs;
   // Frame-reader source and scenario knobs.
   int          src_idx, src_seq;
   bit          k_rst, k_lk, k_rand;
   int          k_drop_pos, k_sop_pos;
   int          cyc;

   function automatic logic [23:0] pix_of(input int seq);
      logic [7:0] x;
      x = seq[7:0];
      return {x, x + 8'd37, x ^ 8'h5a};
   endfunction

   function automatic bit model_ready();
      int h = m_pos % HT;
      int v = m_pos / HT;
      bit act = (h < HA) && (v < VA);
      bit org = (m_pos == 0);
      bit sop = pix_valid && pix_sop;
      if (rst || !pll_locked) return 1'b0;
      if (m_mode == 1) return !sop || org;
      if (m_mode == 2) return act && !(sop && !org);
      return 1'b0;
   endfunction

   task automatic model_edge();
      int          h = m_pos % HT;
      int          v = m_pos / HT;
      bit          act = (h < HA) && (v < VA);
      bit          org = (m_pos == 0);
      bit          good, take;
      logic [23:0] cur = pix_of(src_seq);
      logic [23:0] rgb = '0;
      bit          hs = !POL, vs = !POL, bl = 1'b0, fs = 1'b0;
      if (pix_valid && model_ready()) begin
         src_idx = (src_idx + 1) % NPIX;
         src_seq++;
      end
      if (rst) begin
         m_mode = 0; m_lock = 0; m_pos = 0; m_uf = 1'b0;
      end else if (!pll_locked) begin
         m_mode = 0; m_lock = 0; m_pos = 0;
      end else if (m_mode == 0) begin
         if (m_lock == LW - 1) m_mode = 1;
         else m_lock++;
      end else begin
         if (h >= HA + HFP && h < HA + HFP + HS) hs = POL;
         if (v >= VA + VFP && v < VA + VFP + VS) vs = POL;
         fs   = org;
         take = act && (m_mode == 2 || (org && pix_valid && pix_sop));
         good = pix_valid && (pix_sop == org);
         bl   = take;
         if (take && good) rgb = cur;
         if (take && !good) begin
            m_uf   = 1'b1;
            m_mode = 1;
         end else if (take) begin
            m_mode = 2;
         end
         m_pos = (m_pos + 1) % FRAME;
      end
      m_outs = {hs, vs, bl, fs, m_uf, rgb};
   endtask

   task automatic drive();
      rst        = k_rst;
      pll_locked = k_lk;
      pix_valid  = 1'b1;
      if (m_mode == 2 && k_drop_pos == m_pos) begin
         pix_valid  = 1'b0;
         k_drop_pos = -1;
      end
      if (m_mode == 2 && k_sop_pos == m_pos) begin
         src_idx   = 0;
         k_sop_pos = -1;
      end
      if (k_rand) begin
         if ($urandom_range(199) == 0) pix_valid = 1'b0;
         if ($urandom_range(299) == 0) src_idx = 0;
         if ($urandom_range(999) == 0) pll_locked = 1'b0;
      end
      pix_sop  = (src_idx == 0);
      pix_data = pix_valid ? pix_of(src_seq) : 24'($urandom());
   endtask

   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      model_edge();
      drive();
      #1;
      e.outs = m_outs;
      e.rdy  = model_ready();
      e.cyc  = cyc;
      sb_q.push_back(e);
      cyc++;
   endtask

   task automatic check(input string name, input bit ok, input int got, input int req);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e   = sb_q.pop_front();
         mon_got = {vga_hs, vga_vs, vga_blank_n, frame_start, underflow, vga_r, vga_g, vga_b};
         tests++;
         if (mon_got !== mon_e.outs) begin
            fails++;
            $display("FAIL outputs cyc=%0d {hs,vs,blank_n,fs,uf,rgb} got %b_%b_%b_%b_%b_%h required %b_%b_%b_%b_%b_%h",
                     mon_e.cyc, mon_got[28], mon_got[27], mon_got[26], mon_got[25], mon_got[24],
                     mon_got[23:0], mon_e.outs[28], mon_e.outs[27], mon_e.outs[26],
                     mon_e.outs[25], mon_e.outs[24], mon_e.outs[23:0]);
         end
         tests++;
         if (pix_ready !== mon_e.rdy) begin
            fails++;
            $display("FAIL pix_ready cyc=%0d got %b required %b", mon_e.cyc, pix_ready, mon_e.rdy);
         end
      end
   end

   initial begin
      m_mode = 0; m_lock = 0; m_pos = 0; m_uf = 1'b0; m_outs = '0;
      src_idx = 0; src_seq = 0; cyc = 0;
      k_rst = 1'b1; k_lk = 1'b0; k_rand = 1'b0; k_drop_pos = -1; k_sop_pos = -1;
      drive();
      repeat (4) cycle();
      k_rst = 1'b0;
      repeat (6) cycle();
      k_lk = 1'b1;
      repeat (LW + 4 * FRAME) cycle();

      // Single missing pixel inside the active area.
      k_drop_pos = 2 * HT + 3;
      repeat (3 * FRAME) cycle();
      check("drop_injected", k_drop_pos == -1, k_drop_pos, -1);

      // SOP presented at a non-origin active pixel.
      k_sop_pos = 3;
      repeat (3 * FRAME) cycle();
      check("sop_injected", k_sop_pos == -1, k_sop_pos, -1);

      // Lock loss in the middle of a displayed line.
      for (int i = 0; i < 4 * FRAME && !(m_mode == 2 && m_pos % HT == 5); i++) cycle();
      check("reach_lockloss_point", m_mode == 2 && m_pos % HT == 5, m_pos, 5);
      k_lk = 1'b0;
      repeat (3) cycle();
      k_lk = 1'b1;
      repeat (LW + 3 * FRAME) cycle();

      k_rand = 1'b1;
      repeat (6000) cycle();
      k_rand = 1'b0;
      repeat (2 * FRAME) cycle();

      // Mid-frame reset while displaying.
      for (int i = 0; i < 4 * FRAME && !(m_mode == 2 && m_pos == 3 * HT + 4); i++) cycle();
      check("reach_reset_point", m_mode == 2 && m_pos == 3 * HT + 4, m_pos, 3 * HT + 4);
      k_rst = 1'b1;
      cycle();
      k_rst = 1'b0;
      repeat (LW + 3 * FRAME) cycle();

      @(posedge clk);
      #1;
      check("scoreboard_drained", sb_q.size() == 0, sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
